ucore_seq: RTL



---
 rtl/ucore_seq.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/ucore_seq.sv
// Runtime-loadable microprogram sequencer: 32-bit microinstructions from a writable
// store, flop register file, return stack, valid/ready I/O. Optional UCORE_SEQ_TRACE_EN adds retire trace.
module ucore_seq #(
  parameter int DATA_W      = 16,
  parameter int NREGS       = 8,
  parameter int PROG_DEPTH  = 256,
  parameter int STACK_DEPTH = 4,
  localparam int PC_W       = $clog2(PROG_DEPTH)
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic              prog_we,
  input  logic [PC_W-1:0]   prog_addr,
  input  logic [31:0]       prog_data,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic [2:0]        err_code,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef UCORE_SEQ_TRACE_EN
  ,
  output logic              trace_valid,
  output logic [PC_W-1:0]   trace_pc
`endif
);

  localparam int RI_W  = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int STK_N = 1 << SP_W;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_LDI  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_IN   = 4'd4;
  localparam logic [3:0] OP_OUT  = 4'd5;
  localparam logic [3:0] OP_JMP  = 4'd6;
  localparam logic [3:0] OP_BZ   = 4'd7;
  localparam logic [3:0] OP_BNZ  = 4'd8;
  localparam logic [3:0] OP_CALL = 4'd9;
  localparam logic [3:0] OP_RET  = 4'd10;
  localparam logic [3:0] OP_HALT = 4'd11;

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_OP    = 3'd1;
  localparam logic [2:0] ERR_FULL  = 3'd2;
  localparam logic [2:0] ERR_EMPTY = 3'd3;
  localparam logic [2:0] ERR_IDX   = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT_OUT, S_FAULT} state_t;

  // Handshakes: a word moves on in_* / out_* only in a cycle where valid and ready
  // are both high at the clock edge; out_data is held constant while out_valid waits.

  state_t            state;
  logic [PC_W-1:0]   pc;
  logic [SP_W-1:0]   sp;
  logic [31:0]       prog_mem [PROG_DEPTH];
  logic [DATA_W-1:0] regs [NREGS];
  logic [PC_W-1:0]   stack [STK_N];

  logic [31:0]       instr;
  logic [3:0]        op, rd, rs;
  logic [19:0]       imm;
  logic [RI_W-1:0]   ri_d, ri_s;
  logic              rd_ok, rs_ok, tgt_ok;
  logic [DATA_W-1:0] rd_val, rs_val, imm_d;
  logic [PC_W-1:0]   imm_pc, pc_inc;
  logic              stk_full, stk_empty;
  logic              uses_rd, uses_rs, taken;
  logic [2:0]        cause;
  logic              exec;

  assign instr  = prog_mem[pc];
  assign op     = instr[31:28];
  assign rd     = instr[27:24];
  assign rs     = instr[23:20];
  assign imm    = instr[19:0];
  assign ri_d   = rd[RI_W-1:0];
  assign ri_s   = rs[RI_W-1:0];
  assign rd_ok  = 32'(rd) < NREGS;
  assign rs_ok  = 32'(rs) < NREGS;
  assign tgt_ok = 32'(imm) < PROG_DEPTH;
  assign rd_val = rd_ok ? regs[ri_d] : '0;
  assign rs_val = rs_ok ? regs[ri_s] : '0;
  assign imm_d  = DATA_W'(imm);
  assign imm_pc = imm[PC_W-1:0];
  assign pc_inc = (pc == PC_W'(PROG_DEPTH - 1)) ? '0 : pc + 1'b1;
  assign stk_full  = (sp == SP_W'(STACK_DEPTH));
  assign stk_empty = (sp == '0);

  // Target range is only a fault when the branch would actually be taken.
  always_comb begin
    uses_rd = 1'b0;
    uses_rs = 1'b0;
    taken   = 1'b0;
    case (op)
      OP_LDI, OP_IN, OP_OUT: uses_rd = 1'b1;
      OP_ADD, OP_SUB: begin
        uses_rd = 1'b1;
        uses_rs = 1'b1;
      end
      OP_BZ: begin
        uses_rd = 1'b1;
        taken   = (rd_val == '0);
      end
      OP_BNZ: begin
        uses_rd = 1'b1;
        taken   = (rd_val != '0);
      end
      OP_JMP, OP_CALL: taken = 1'b1;
      default: ;
    endcase
    cause = ERR_NONE;
    if (op >= 4'd12)                                       cause = ERR_OP;
    else if ((uses_rd && !rd_ok) || (uses_rs && !rs_ok))   cause = ERR_IDX;
    else if (taken && !tgt_ok)                             cause = ERR_IDX;
    else if (op == OP_CALL && stk_full)                    cause = ERR_FULL;
    else if (op == OP_RET && stk_empty)                    cause = ERR_EMPTY;
  end

  assign in_ready = (state == S_RUN) && (op == OP_IN) && (cause == ERR_NONE);
  assign exec     = (state == S_RUN) && (cause == ERR_NONE) && !((op == OP_IN) && !in_valid);
  assign busy     = (state == S_RUN) || (state == S_WAIT_OUT);
  assign fault    = (state == S_FAULT);

  always_ff @(posedge clk) begin
    if (prog_we && (state == S_IDLE || state == S_FAULT))
      prog_mem[prog_addr] <= prog_data;
  end

  always_ff @(posedge clk) begin
    if (exec && op == OP_CALL)
      stack[sp] <= pc_inc;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= S_IDLE;
      pc        <= '0;
      sp        <= '0;
      done      <= 1'b0;
      err_code  <= ERR_NONE;
      out_valid <= 1'b0;
      out_data  <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_FAULT: begin
          if (start) begin
            state    <= S_RUN;
            pc       <= '0;
            sp       <= '0;
            err_code <= ERR_NONE;
          end
        end
        S_RUN: begin
          if (cause != ERR_NONE) begin
            state    <= S_FAULT;
            err_code <= cause;
          end else begin
            case (op)
              OP_LDI: begin
                regs[ri_d] <= imm_d;
                pc         <= pc_inc;
              end
              OP_ADD: begin
                regs[ri_d] <= rd_val + rs_val;
                pc         <= pc_inc;
              end
              OP_SUB: begin
                regs[ri_d] <= rd_val - rs_val;
                pc         <= pc_inc;
              end
              OP_IN: begin
                if (in_valid) begin
                  regs[ri_d] <= in_data;
                  pc         <= pc_inc;
                end
              end
              OP_OUT: begin
                out_data  <= rd_val;
                out_valid <= 1'b1;
                pc        <= pc_inc;
                state     <= S_WAIT_OUT;
              end
              OP_JMP:  pc <= imm_pc;
              OP_BZ, OP_BNZ: pc <= taken ? imm_pc : pc_inc;
              OP_CALL: begin
                sp <= sp + 1'b1;
                pc <= imm_pc;
              end
              OP_RET: begin
                sp <= sp - 1'b1;
                pc <= stack[sp - 1'b1];
              end
              OP_HALT: begin
                done  <= 1'b1;
                state <= S_IDLE;
                pc    <= '0;
              end
              default: pc <= pc_inc;
            endcase
          end
        end
        S_WAIT_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_RUN;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef UCORE_SEQ_TRACE_EN
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      trace_valid <= 1'b0;
      trace_pc    <= '0;
    end else begin
      trace_valid <= exec;
      if (exec) trace_pc <= pc;
    end
  end
`endif

endmodule
